// File: rtl/banner_key_ctrl.sv
// Banner control front-end: debounces four board keys into saturating size/speed
// settings and paces the horizontal scroll position off the frame tick.

module bkc_key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1, s, stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      s      <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_raw;
      s     <= sync1;
      press <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Accept the new level; only a fall (key pressed) is an event.
        stable <= s;
        cnt    <= '0;
        press  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module banner_key_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int BANNER_W  = 640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       frame_tick,
  output logic [1:0] char_size,
  output logic [1:0] scroll_speed,
  output logic       scroll_step,
  output logic [9:0] scroll_pos
);
  localparam int NUM_KEYS = 4;
  localparam logic [9:0] POS_LAST = 10'(BANNER_W - 1);

  logic [NUM_KEYS-1:0] press;
  logic [2:0]          frame_cnt;
  logic [2:0]          period_m1;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    bkc_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_raw(key[g]),
      .press  (press[g])
    );
  end

  function automatic logic [1:0] sat_adj(input logic [1:0] v, input logic up, input logic dn);
    logic [1:0] r;
    r = v;
    if (up && !dn && v != 2'd3) r = v + 2'd1;
    if (dn && !up && v != 2'd0) r = v - 2'd1;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_size    <= 2'd0;
      scroll_speed <= 2'd0;
    end else begin
      char_size    <= sat_adj(char_size, press[0], press[1]);
      scroll_speed <= sat_adj(scroll_speed, press[2], press[3]);
    end
  end

  // Period minus one: 7, 3, 1, 0 frames for speed 0..3.
  assign period_m1 = 3'd7 >> scroll_speed;

  // >= rather than == so a speed raise mid-count steps on the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= 3'd0;
      scroll_step <= 1'b0;
      scroll_pos  <= 10'd0;
    end else begin
      scroll_step <= 1'b0;
      if (frame_tick) begin
        if (frame_cnt >= period_m1) begin
          frame_cnt   <= 3'd0;
          scroll_step <= 1'b1;
          scroll_pos  <= (scroll_pos == POS_LAST) ? 10'd0 : scroll_pos + 10'd1;
        end else begin
          frame_cnt <= frame_cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_banner_key_ctrl.sv
// Directed plus random bench for banner_key_ctrl against a cycle-stepped reference model.

module tb_banner_key_ctrl;
  localparam int DB = 4;
  localparam int W  = 4;

  logic       clk, rst_n, frame_tick, scroll_step;
  logic [3:0] key;
  logic [1:0] char_size, scroll_speed;
  logic [9:0] scroll_pos;

  int checks = 0;
  int errors = 0;

  banner_key_ctrl #(.DB_CYCLES(DB), .BANNER_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .frame_tick  (frame_tick),
    .char_size   (char_size),
    .scroll_speed(scroll_speed),
    .scroll_step (scroll_step),
    .scroll_pos  (scroll_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  int         m_size, m_speed, m_pos, m_ticks;
  bit         m_step;
  logic [3:0] kd1, kd2, stab, pend;
  int         run [4];

  task automatic model_reset();
    m_size = 0; m_speed = 0; m_pos = 0; m_ticks = 0; m_step = 0;
    kd1 = 4'hF; kd2 = 4'hF; stab = 4'hF; pend = 4'h0;
    for (int i = 0; i < 4; i++) run[i] = 0;
  endtask

  task automatic model_edge(input logic [3:0] k, input logic ft);
    logic [3:0] np;
    m_step = 0;
    if (ft) begin
      m_ticks++;
      if (m_ticks >= (8 >> m_speed)) begin
        m_ticks = 0;
        m_step  = 1;
        m_pos   = (m_pos + 1) % W;
      end
    end
    if (pend[0] && !pend[1] && m_size < 3) m_size++;
    if (pend[1] && !pend[0] && m_size > 0) m_size--;
    if (pend[2] && !pend[3] && m_speed < 3) m_speed++;
    if (pend[3] && !pend[2] && m_speed > 0) m_speed--;
    np = 4'h0;
    for (int i = 0; i < 4; i++) begin
      // A level is accepted once DB consecutive samples disagree with the held one.
      run[i] = (kd2[i] != stab[i]) ? run[i] + 1 : 0;
      if (run[i] == DB) begin
        if (kd2[i] == 1'b0) np[i] = 1'b1;
        stab[i] = kd2[i];
        run[i]  = 0;
      end
    end
    pend = np;
    kd2 = kd1;
    kd1 = k;
  endtask

  function automatic logic [31:0] dut_outs();
    return {17'd0, char_size, scroll_speed, scroll_step, scroll_pos};
  endfunction

  function automatic logic [31:0] model_outs();
    return {17'd0, 2'(m_size), 2'(m_speed), m_step, 10'(m_pos)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1; drives inputs for one edge, steps the model, compares.
  task automatic cyc(input logic [3:0] k, input logic ft);
    key = k;
    frame_tick = ft;
    @(posedge clk);
    model_edge(k, ft);
    #1;
    chk("cycle", dut_outs(), model_outs());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_async", dut_outs(), 32'd0);
    key = 4'($urandom);
    frame_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", dut_outs(), 32'd0);
    key = 4'hF;
    frame_tick = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [3:0] k);
    repeat (8) cyc(k, 1'b0);
    repeat (8) cyc(4'hF, 1'b0);
  endtask

  int         steps;
  logic [3:0] rk;

  initial begin
    rst_n = 1'b1;
    key = 4'hF;
    frame_tick = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Debounce accept: size changes exactly on the 7th edge of the hold
    for (int i = 1; i <= 20; i++) begin
      cyc(4'hE, 1'b0);
      if (i == 6) chk("accept_edge6", 32'(char_size), 32'd0);
      if (i == 7) chk("accept_edge7", 32'(char_size), 32'd1);
    end
    chk("accept_hold", 32'(char_size), 32'd1);
    repeat (10) cyc(4'hF, 1'b0);

    // Bounce reject
    repeat (3) cyc(4'hE, 1'b0);
    repeat (2) cyc(4'hF, 1'b0);
    repeat (3) cyc(4'hE, 1'b0);
    repeat (12) cyc(4'hF, 1'b0);
    chk("bounce_reject", 32'(char_size), 32'd1);

    // Saturation
    repeat (5) press(4'hE);
    chk("size_sat_hi", 32'(char_size), 32'd3);
    repeat (5) press(4'hD);
    chk("size_sat_lo", 32'(char_size), 32'd0);
    repeat (5) press(4'hB);
    chk("speed_sat_hi", 32'(scroll_speed), 32'd3);
    repeat (5) press(4'h7);
    chk("speed_sat_lo", 32'(scroll_speed), 32'd0);

    // Simultaneous size up/down plus speed up
    press(4'h8);
    chk("simul_size", 32'(char_size), 32'd0);
    chk("simul_speed", 32'(scroll_speed), 32'd1);
    press(4'h7);

    // Pacing at speed 0: steps on ticks 8, 16, 24
    steps = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(4'hF, 1'b1);
      chk("pace0_step", 32'(scroll_step), 32'(i % 8 == 0));
      steps += int'(scroll_step);
      repeat (2) cyc(4'hF, 1'b0);
    end
    chk("pace0_count", 32'(steps), 32'd3);
    chk("pace0_pos", 32'(scroll_pos), 32'd3);

    repeat (3) press(4'hB);
    steps = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(4'hF, 1'b1);
      steps += int'(scroll_step);
      cyc(4'hF, 1'b0);
    end
    chk("pace3_count", 32'(steps), 32'd10);

    // Wrap sequence from reset with BANNER_W = 4
    do_reset();
    repeat (3) press(4'hB);
    for (int i = 0; i < 6; i++) begin
      cyc(4'hF, 1'b1);
      chk("wrap_pos", 32'(scroll_pos), 32'((i + 1) % 4));
      cyc(4'hF, 1'b0);
    end

    // Reset mid-debounce and mid-count: no press after release
    repeat (3) cyc(4'hE, 1'b1);
    do_reset();
    repeat (12) cyc(4'hF, 1'b0);
    chk("post_reset_size", 32'(char_size), 32'd0);

    // Random slow-changing keys and ticks, occasional reset
    rk = 4'hF;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) rk[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc(rk, 1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
